// File: rtl/constraint_eval_engine.sv
// Runtime-programmable constraint evaluation engine.
// Holds a table of constraints, accepts one candidate vector at a time and evaluates one table
// entry per cycle. It reports the overall pass, a per-constraint mask and the lowest failing
// index, and keeps saturating sample/pass statistics.
module constraint_eval_engine #(
    parameter int NUM_VARS   = 5,
    parameter int VAR_W      = 14,
    parameter int NUM_CONS   = 9,
    parameter int EARLY_EXIT = 0,
    parameter int CNT_W      = 16,
    localparam int IDX_W = ($clog2(NUM_VARS) > 1) ? $clog2(NUM_VARS) : 1,
    localparam int CI_W  = ($clog2(NUM_CONS) > 1) ? $clog2(NUM_CONS) : 1,
    localparam int CFG_W = 1 + 3 + 1 + 2 * IDX_W + VAR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [CI_W-1:0]           cfg_idx,
    input  logic [CFG_W-1:0]          cfg_data,
    output logic                      cfg_err,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_pass,
    output logic [NUM_CONS-1:0]       out_mask,
    output logic [CI_W-1:0]           out_fail_idx,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic [CNT_W-1:0]          pass_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_INV = 3'd7;

    logic [1:0]                state_q;
    logic [CI_W-1:0]           idx_q;
    logic [NUM_VARS*VAR_W-1:0] vars_q;
    logic [NUM_CONS-1:0]       mask_q;
    logic                      pass_q;
    logic [CI_W-1:0]           fail_q;
    logic                      cfg_err_q;
    logic [CNT_W-1:0]          sample_q;
    logic [CNT_W-1:0]          pass_cnt_q;
    logic [CFG_W-1:0]          table_q [NUM_CONS];

    logic                      cfg_idx_ok;
    logic                      cfg_accept;
    logic                      accept;
    logic                      deliver;

    // Fields of the entry currently under evaluation
    logic [CFG_W-1:0]          cur;
    logic                      cur_en;
    logic [2:0]                cur_op;
    logic                      cur_use_imm;
    logic [IDX_W-1:0]          cur_a_idx;
    logic [IDX_W-1:0]          cur_b_idx;
    logic [VAR_W-1:0]          cur_imm;

    logic [VAR_W-1:0]          op_a;
    logic [VAR_W-1:0]          op_b_var;
    logic [VAR_W-1:0]          op_b;
    logic [VAR_W-1:0]          result;
    logic                      ent_pass;
    logic                      last_ent;
    logic                      stop;

    assign cfg_idx_ok = {1'b0, cfg_idx} < (CI_W + 1)'(NUM_CONS);
    assign cfg_accept = cfg_we && (state_q == S_IDLE) && cfg_idx_ok;
    assign accept     = in_valid && (state_q == S_IDLE);
    assign deliver    = out_ready && (state_q == S_DONE);

    assign cur         = table_q[idx_q];
    assign cur_en      = cur[CFG_W-1];
    assign cur_op      = cur[CFG_W-2 -: 3];
    assign cur_use_imm = cur[CFG_W-5];
    assign cur_a_idx   = cur[VAR_W+2*IDX_W-1 -: IDX_W];
    assign cur_b_idx   = cur[VAR_W+IDX_W-1 -: IDX_W];
    assign cur_imm     = cur[VAR_W-1:0];

    // Operand fetch; indices beyond the variable count read as zero
    always_comb begin
        op_a     = '0;
        op_b_var = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (cur_a_idx == IDX_W'(i)) op_a = vars_q[i*VAR_W +: VAR_W];
            if (cur_b_idx == IDX_W'(i)) op_b_var = vars_q[i*VAR_W +: VAR_W];
        end
        op_b = cur_use_imm ? cur_imm : op_b_var;
    end

    // Constraint ALU; every result truncated to VAR_W bits
    always_comb begin
        result = '0;
        case (cur_op)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_AND:  result = op_a & op_b;
            OP_SHL:  result = op_a << op_b;
            OP_SHR:  result = op_a >> op_b;
            OP_NOT:  result = {{(VAR_W-1){1'b0}}, (op_a == '0)};
            OP_INV:  result = ~op_a;
            default: result = '0;
        endcase
    end

    // A disabled entry passes unconditionally but still occupies its cycle
    assign ent_pass = !cur_en || (|result);
    assign last_ent = (idx_q == CI_W'(NUM_CONS - 1));
    assign stop     = last_ent || ((EARLY_EXIT != 0) && !ent_pass);

    // Constraint table; writes only land while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONS; i++) table_q[i] <= '0;
        end else if (cfg_accept) begin
            table_q[cfg_idx] <= cfg_data;
        end
    end

    // One-cycle error pulse for every dropped configuration write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_we && !cfg_accept;
    end

    // Control FSM and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            vars_q  <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        vars_q  <= in_vars;
                        idx_q   <= '0;
                        mask_q  <= '0;
                        pass_q  <= 1'b1;
                        fail_q  <= '0;
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    mask_q[idx_q] <= ent_pass;
                    // Only the first failure seen is the lowest failing index
                    if (!ent_pass && pass_q) begin
                        pass_q <= 1'b0;
                        fail_q <= idx_q;
                    end
                    if (stop) state_q <= S_DONE;
                    else      idx_q   <= idx_q + CI_W'(1);
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Saturating statistics; a clear wins over a same-cycle delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q   <= '0;
            pass_cnt_q <= '0;
        end else if (cnt_clr) begin
            sample_q   <= '0;
            pass_cnt_q <= '0;
        end else if (deliver) begin
            if (sample_q != {CNT_W{1'b1}}) sample_q <= sample_q + CNT_W'(1);
            if (pass_q && (pass_cnt_q != {CNT_W{1'b1}})) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
        end
    end

    assign cfg_err      = cfg_err_q;
    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_pass     = pass_q;
    assign out_mask     = mask_q;
    assign out_fail_idx = fail_q;
    assign sample_cnt   = sample_q;
    assign pass_cnt     = pass_cnt_q;

endmodule

// File: tb/tb_constraint_eval_engine.sv
// Directed bench for constraint_eval_engine: dut0 uses default parameters, dut1 enables early
// exit with 2-bit counters.
module tb_constraint_eval_engine;

    localparam int NV   = 5;
    localparam int VW   = 14;
    localparam int NC   = 9;
    localparam int CIW  = 4;
    localparam int CFGW = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]             cfg_we, in_valid, out_ready, cnt_clr;
    logic [1:0]             cfg_err, in_ready, out_valid, out_pass;
    logic [1:0][CIW-1:0]    cfg_idx, fail_idx;
    logic [1:0][CFGW-1:0]   cfg_data;
    logic [1:0][NV*VW-1:0]  in_vars;
    logic [1:0][NC-1:0]     out_mask;
    logic [15:0]            sc0, pc0;
    logic [1:0]             sc1, pc1;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    constraint_eval_engine #(
        .NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .EARLY_EXIT(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we[0]), .cfg_idx(cfg_idx[0]), .cfg_data(cfg_data[0]), .cfg_err(cfg_err[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vars(in_vars[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pass(out_pass[0]),
        .out_mask(out_mask[0]), .out_fail_idx(fail_idx[0]),
        .cnt_clr(cnt_clr[0]), .sample_cnt(sc0), .pass_cnt(pc0)
    );

    constraint_eval_engine #(
        .NUM_VARS(NV), .VAR_W(VW), .NUM_CONS(NC), .EARLY_EXIT(1), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we[1]), .cfg_idx(cfg_idx[1]), .cfg_data(cfg_data[1]), .cfg_err(cfg_err[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vars(in_vars[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pass(out_pass[1]),
        .out_mask(out_mask[1]), .out_fail_idx(fail_idx[1]),
        .cnt_clr(cnt_clr[1]), .sample_cnt(sc1), .pass_cnt(pc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CFGW-1:0] mk(input logic en, input logic [2:0] op, input logic ui,
                                           input logic [2:0] a, input logic [2:0] b,
                                           input logic [VW-1:0] imm);
        return {en, op, ui, a, b, imm};
    endfunction

    function automatic logic [NV*VW-1:0] pack(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                                              input logic [VW-1:0] v2, input logic [VW-1:0] v3,
                                              input logic [VW-1:0] v4);
        return {v4, v3, v2, v1, v0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int d, input logic [CIW-1:0] idx, input logic [CFGW-1:0] data);
        cfg_we[d] = 1'b1;
        cfg_idx[d] = idx;
        cfg_data[d] = data;
        tick();
        cfg_we[d] = 1'b0;
        check("cfg_ok_no_err", 32'(cfg_err[d]), 32'd0);
    endtask

    // Handshake one candidate, then count edges until out_valid (bounded)
    task automatic run(input int d, input logic [NV*VW-1:0] v, output int l);
        int w = 0;
        while (!in_ready[d] && w < 50) begin
            tick();
            w++;
        end
        check("in_ready_wait", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_vars[d] = v;
        tick();
        in_valid[d] = 1'b0;
        l = 0;
        while (!out_valid[d] && l < 60) begin
            tick();
            l++;
        end
    endtask

    task automatic expect_res(input string tag, input int d, input int l, input int exp_lat,
                              input logic p, input logic [NC-1:0] m, input logic [CIW-1:0] f);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_valid"}, 32'(out_valid[d]), 32'd1);
        check({tag, "_pass"}, 32'(out_pass[d]), 32'(p));
        check({tag, "_mask"}, 32'(out_mask[d]), 32'(m));
        check({tag, "_fail"}, 32'(fail_idx[d]), 32'(f));
    endtask

    task automatic deliver(input int d, input logic clr);
        out_ready[d] = 1'b1;
        cnt_clr[d] = clr;
        tick();
        out_ready[d] = 1'b0;
        cnt_clr[d] = 1'b0;
        check("deliver_valid_low", 32'(out_valid[d]), 32'd0);
    endtask

    initial begin
        logic [NV*VW-1:0] v5a, v5b;
        int seen;
        cfg_we = '0; in_valid = '0; out_ready = '0; cnt_clr = '0;
        cfg_idx = '0; cfg_data = '0; in_vars = '0;
        v5a = pack(14'h0000, 14'h00F0, 14'h1234, 14'h0001, 14'h3FFF);
        v5b = pack(14'h0000, 14'h00F0, 14'h1234, 14'h0001, 14'h2000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_pass", 32'(out_pass[0]), 32'd0);
        check("rst_out_mask", 32'(out_mask[0]), 32'd0);
        check("rst_fail_idx", 32'(fail_idx[0]), 32'd0);
        check("rst_cfg_err", 32'(cfg_err[0]), 32'd0);
        check("rst_sample_cnt", 32'(sc0), 32'd0);
        check("rst_pass_cnt", 32'(pc0), 32'd0);
        check("rst_in_ready1", 32'(in_ready[1]), 32'd1);

        // Empty table: everything passes, full-length latency
        run(0, pack(14'h0, 14'h0, 14'h0, 14'h0, 14'h0), lat);
        expect_res("empty", 0, lat, 9, 1'b1, 9'h1FF, 4'd0);
        deliver(0, 1'b0);
        check("empty_sample_cnt", 32'(sc0), 32'd1);
        check("empty_pass_cnt", 32'(pc0), 32'd1);

        // var2 - 0x39dd must be nonzero
        cfg_write(0, 4'd0, mk(1'b1, 3'd1, 1'b1, 3'd2, 3'd0, 14'h39dd));
        run(0, pack(14'h0, 14'h0, 14'h39dd, 14'h0, 14'h0), lat);
        expect_res("sub_eq", 0, lat, 9, 1'b0, 9'h1FE, 4'd0);
        deliver(0, 1'b0);
        run(0, pack(14'h0, 14'h0, 14'h1234, 14'h0, 14'h0), lat);
        expect_res("sub_ne", 0, lat, 9, 1'b1, 9'h1FF, 4'd0);
        deliver(0, 1'b0);
        check("cnt3_sample", 32'(sc0), 32'd3);
        check("cnt3_pass", 32'(pc0), 32'd2);

        // Shift by 9 passes, !var0 with var0=0 passes
        cfg_write(0, 4'd1, mk(1'b1, 3'd4, 1'b1, 3'd3, 3'd0, 14'd9));
        cfg_write(0, 4'd3, mk(1'b1, 3'd6, 1'b0, 3'd0, 3'd0, 14'd0));
        run(0, pack(14'h0, 14'h0, 14'h1234, 14'h0001, 14'h0), lat);
        expect_res("shl9", 0, lat, 9, 1'b1, 9'h1FF, 4'd0);
        deliver(0, 1'b0);

        // Shift by 14 truncates to zero
        cfg_write(0, 4'd1, mk(1'b1, 3'd4, 1'b1, 3'd3, 3'd0, 14'd14));
        run(0, pack(14'h0, 14'h0, 14'h1234, 14'h0001, 14'h0), lat);
        expect_res("shl14", 0, lat, 9, 1'b0, 9'h1FD, 4'd1);
        deliver(0, 1'b0);

        // Two failures: lowest index reported
        run(0, pack(14'h7, 14'h0, 14'h1234, 14'h0001, 14'h0), lat);
        expect_res("two_fail", 0, lat, 9, 1'b0, 9'h1F5, 4'd1);
        deliver(0, 1'b0);

        // Remaining ops and out-of-range operand indices
        cfg_write(0, 4'd1, mk(1'b0, 3'd4, 1'b1, 3'd3, 3'd0, 14'd14));
        cfg_write(0, 4'd4, mk(1'b1, 3'd2, 1'b0, 3'd0, 3'd1, 14'd0));
        cfg_write(0, 4'd5, mk(1'b1, 3'd7, 1'b0, 3'd4, 3'd0, 14'd0));
        cfg_write(0, 4'd6, mk(1'b1, 3'd0, 1'b0, 3'd7, 3'd7, 14'd0));
        cfg_write(0, 4'd7, mk(1'b1, 3'd5, 1'b1, 3'd4, 3'd0, 14'd13));
        cfg_write(0, 4'd8, mk(1'b1, 3'd3, 1'b0, 3'd1, 3'd4, 14'd0));
        run(0, v5a, lat);
        expect_res("ops_a", 0, lat, 9, 1'b0, 9'h19F, 4'd5);
        deliver(0, 1'b0);
        run(0, v5b, lat);
        expect_res("ops_b", 0, lat, 9, 1'b0, 9'h0BF, 4'd6);
        deliver(0, 1'b0);
        check("cnt8_sample", 32'(sc0), 32'd8);
        check("cnt8_pass", 32'(pc0), 32'd3);

        // Back-pressure: outputs held, config writes dropped with an error pulse
        run(0, v5b, lat);
        expect_res("hold", 0, lat, 9, 1'b0, 9'h0BF, 4'd6);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid[0]), 32'd1);
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
            check("hold_mask", 32'(out_mask[0]), 32'h0BF);
            check("hold_fail", 32'(fail_idx[0]), 32'd6);
            if (i == 1) begin
                cfg_we[0] = 1'b1;
                cfg_idx[0] = 4'd6;
                cfg_data[0] = mk(1'b0, 3'd0, 1'b0, 3'd7, 3'd7, 14'd0);
            end
            tick();
            if (i == 1) begin
                cfg_we[0] = 1'b0;
                check("busy_cfg_err", 32'(cfg_err[0]), 32'd1);
            end
        end
        check("hold_cnt_before", 32'(sc0), 32'd8);
        deliver(0, 1'b0);
        check("hold_cnt_after", 32'(sc0), 32'd9);
        tick();
        check("hold_cnt_once", 32'(sc0), 32'd9);
        check("cfg_err_pulse_end", 32'(cfg_err[0]), 32'd0);

        // The dropped write must not have reached the table
        run(0, v5b, lat);
        expect_res("after_drop", 0, lat, 9, 1'b0, 9'h0BF, 4'd6);
        deliver(0, 1'b0);

        // Bad index while idle
        cfg_we[0] = 1'b1;
        cfg_idx[0] = 4'd9;
        cfg_data[0] = mk(1'b1, 3'd0, 1'b0, 3'd7, 3'd7, 14'd0);
        tick();
        cfg_we[0] = 1'b0;
        check("bad_idx_err", 32'(cfg_err[0]), 32'd1);
        tick();
        check("bad_idx_err_clr", 32'(cfg_err[0]), 32'd0);

        // Config write and handshake in the same cycle: new entry applies
        cfg_we[0] = 1'b1;
        cfg_idx[0] = 4'd6;
        cfg_data[0] = mk(1'b0, 3'd0, 1'b0, 3'd7, 3'd7, 14'd0);
        in_valid[0] = 1'b1;
        in_vars[0] = v5b;
        tick();
        cfg_we[0] = 1'b0;
        in_valid[0] = 1'b0;
        check("same_cycle_err", 32'(cfg_err[0]), 32'd0);
        lat = 0;
        while (!out_valid[0] && lat < 60) begin
            tick();
            lat++;
        end
        expect_res("same_cycle", 0, lat, 9, 1'b0, 9'h0FF, 4'd8);
        deliver(0, 1'b0);
        check("cnt11_sample", 32'(sc0), 32'd11);

        // Early exit with 2-bit saturating counters
        cfg_write(1, 4'd2, mk(1'b1, 3'd6, 1'b0, 3'd0, 3'd0, 14'd0));
        run(1, pack(14'd5, 14'h0, 14'h0, 14'h0, 14'h0), lat);
        expect_res("early", 1, lat, 3, 1'b0, 9'h003, 4'd2);
        deliver(1, 1'b0);
        check("early_sample", 32'(sc1), 32'd1);
        check("early_pass", 32'(pc1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            run(1, pack(14'd0, 14'h0, 14'h0, 14'h0, 14'h0), lat);
            expect_res("sat_run", 1, lat, 9, 1'b1, 9'h1FF, 4'd0);
            deliver(1, 1'b0);
        end
        check("sat_sample", 32'(sc1), 32'd3);
        check("sat_pass", 32'(pc1), 32'd3);
        run(1, pack(14'd0, 14'h0, 14'h0, 14'h0, 14'h0), lat);
        deliver(1, 1'b1);
        check("clr_sample", 32'(sc1), 32'd0);
        check("clr_pass", 32'(pc1), 32'd0);

        // Reset mid-evaluation: no result, table cleared
        in_valid[0] = 1'b1;
        in_vars[0] = v5b;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_sample", 32'(sc0), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid[0]) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run(0, v5b, lat);
        expect_res("midrst_cleared", 0, lat, 9, 1'b1, 9'h1FF, 4'd0);
        deliver(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
